mdr_ctrl: RTL and testbench
===========================

// Module: mdr_ctrl
// PURPOSE
//  Parametrised memory data register with a memory-read handshake, byte/half lane
//  extraction, sign/zero extension and a wait-state timeout. Sits between the CPU
//  bus and the memory port. It can load from BusMuxOut in one cycle, or it can run a
//  req/ack read that fills MDRout from Mdatain.
// PARAMETERS
//  WIDTH      32  data width; a multiple of 16 and >= 16; LANES = WIDTH/8
//  RESET_VAL  0   value of MDRout after reset
//  TIMEOUT    15  WAIT cycles without mem_ack before abort (1..255)
// PORTS
//  clk        in   1                   clock; all state changes on its rising edge
//  clr        in   1                   asynchronous, active-low reset (0 = reset)
//  enable     in   1                   load/start strobe, sampled on the clk edge
//  read       in   1                   1 = start a memory read; 0 = load from BusMuxOut
//  BusMuxOut  in   WIDTH               bus data for a direct load
//  size       in   2                   00 byte, 01 half, 10/11 full WIDTH
//  sign_ext   in   1                   1 = sign-extend byte/half; 0 = zero-extend
//  addr_lo    in   $clog2(LANES)       byte-lane select within the word
//  Mdatain    in   WIDTH               memory read data, valid while mem_ack = 1
//  mem_ack    in   1                   memory completion
//  mem_req    out  1                   registered read request
//  MDRout     out  WIDTH               register contents
//  busy       out  1                   1 while state is WAIT
//  done       out  1                   one-cycle pulse after a successful read capture
//  err        out  1                   sticky: misalignment or timeout on the last read
// BEHAVIOUR
//  - Reset (clr = 0, asynchronous): MDRout = RESET_VAL; mem_req, busy, done, err = 0;
//    state = IDLE; counter = 0. A reset during WAIT aborts the read immediately.
//  - States: IDLE, WAIT. mem_req = busy = (state == WAIT); both are registered.
//  - IDLE, enable = 1, read = 0:
//    MDRout <= BusMuxOut at the same edge (latency 1); err unchanged.
//  - IDLE, enable = 1, read = 1:
//    size, sign_ext and addr_lo are latched, and err is cleared.
//    Misaligned request (size = 01 and addr_lo[0] = 1; or size = 1x and addr_lo != 0):
//    err <= 1, no request is issued, state stays IDLE.
//    Aligned request: state <= WAIT, counter <= 0, and mem_req is high from the
//    next cycle.
//  - WAIT, mem_ack = 1 at an edge:
//    MDRout <= extracted value; state <= IDLE; done <= 1 for exactly one cycle.
//    mem_ack can be high in the first WAIT cycle, giving a minimum read of 2 edges.
//  - WAIT, mem_ack = 0: counter++. On the edge where the counter equals TIMEOUT-1:
//    err <= 1, state <= IDLE, mem_req drops, MDRout is unchanged, and done is not
//    pulsed.
//  - enable is ignored in WAIT (no BusMuxOut load, no restart).
//  - mem_ack is ignored in IDLE.
//  - Extraction uses the latched fields:
//    byte = Mdatain[8*addr_lo +: 8]; half = Mdatain[16*addr_lo[msb:1] +: 16];
//    full = Mdatain.
//    Narrow values are extended to WIDTH: copy of the MSB if sign_ext, else zeros.
//  - done is 0 in every cycle other than the one following a capture.
//  - err holds until the next read start or a reset.
// TESTING
//  1 Reset: clr = 0 mid-operation
//    -> MDRout = RESET_VAL, mem_req/busy/done/err = 0, asynchronously (no clk edge).
//  2 Direct load: enable = 1, read = 0, BusMuxOut = 32'hDEADBEEF
//    -> MDRout = DEADBEEF after 1 edge; mem_req stays 0.
//  3 Byte read: size = 00, addr_lo = 2, sign_ext = 1, ack after 3 WAIT cycles,
//    Mdatain = 32'h0080_0000 -> MDRout = FFFFFF80, done = 1 for 1 cycle.
//    With sign_ext = 0 -> 00000080.
//  4 Half read: size = 01, addr_lo = 2, Mdatain = 32'h8001_1234, zero-extend
//    -> MDRout = 00008001.
//    Same request with addr_lo = 1 -> err = 1, mem_req never asserted.
//  5 Timeout: aligned word read, mem_ack held 0
//    -> mem_req high for exactly TIMEOUT cycles, then err = 1, MDRout unchanged.
//    The next successful read clears err.
//  6 WIDTH = 64: word read with Mdatain = 64'h0123456789ABCDEF, size = 10 -> full
//    capture. Byte read with addr_lo = 7 and zero-extend -> MDRout = 64'h01.
//    enable pulses during WAIT -> ignored.

Source files
------------

// File: rtl/mdr_ctrl.sv
// Memory data register: single-cycle bus load or req/ack memory read with lane
// extraction, sign/zero extension, misalignment check and wait-state timeout.
module mdr_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               TIMEOUT   = 15
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         enable,
    input  logic                         read,
    input  logic [WIDTH-1:0]             BusMuxOut,
    input  logic [1:0]                   size,
    input  logic                         sign_ext,
    input  logic [$clog2(WIDTH/8)-1:0]   addr_lo,
    input  logic [WIDTH-1:0]             Mdatain,
    input  logic                         mem_ack,
    output logic                         mem_req,
    output logic [WIDTH-1:0]             MDRout,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int         AW       = $clog2(WIDTH/8);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_WAIT   = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;
    logic [AW-1:0]    addr_q, addr_d;

    // Narrow lanes are right-justified, then filled with their MSB or zeros.
    function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       sz,
                                                 input logic             se,
                                                 input logic [AW-1:0]    a);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a +: 8];
        h = d[16*(a >> 1) +: 16];
        case (sz)
            2'b00:   return {{(WIDTH-8){se & b[7]}}, b};
            2'b01:   return {{(WIDTH-16){se & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [AW-1:0] a);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return |a;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (!read) begin
                        mdr_d = BusMuxOut;
                    end else begin
                        size_d = size;
                        sext_d = sign_ext;
                        addr_d = addr_lo;
                        if (misaligned(size, addr_lo)) begin
                            err_d = 1'b1;
                        end else begin
                            err_d   = 1'b0;
                            state_d = S_WAIT;
                            cnt_d   = 8'd0;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mdr_d   = extract(Mdatain, size_q, sext_q, addr_q);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            mdr_q   <= RESET_VAL;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_req = (state_q == S_WAIT);
    assign busy    = (state_q == S_WAIT);
    assign MDRout  = mdr_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mdr_ctrl.sv
// Bench for mdr_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model (32-bit), and a 64-bit instance.
module tb_mdr_ctrl;

    localparam int          TO   = 15;
    localparam int          TO64 = 4;
    localparam logic [31:0] RV   = 32'h0000_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, enable, read, sign_ext, mem_ack;
    logic [31:0] bus, mdat, mdr;
    logic [1:0]  size, addr;
    logic        mem_req, busy, done, err;

    logic        enable6, read6, sext6, ack6;
    logic [63:0] bus6, mdat6, mdr6;
    logic [1:0]  size6;
    logic [2:0]  addr6;
    logic        req6, busy6, done6, err6;

    mdr_ctrl #(.WIDTH(32), .RESET_VAL(RV), .TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .enable(enable), .read(read), .BusMuxOut(bus),
        .size(size), .sign_ext(sign_ext), .addr_lo(addr), .Mdatain(mdat),
        .mem_ack(mem_ack), .mem_req(mem_req), .MDRout(mdr), .busy(busy),
        .done(done), .err(err)
    );

    mdr_ctrl #(.WIDTH(64), .RESET_VAL(64'h0), .TIMEOUT(TO64)) dut64 (
        .clk(clk), .clr(clr), .enable(enable6), .read(read6), .BusMuxOut(bus6),
        .size(size6), .sign_ext(sext6), .addr_lo(addr6), .Mdatain(mdat6),
        .mem_ack(ack6), .mem_req(req6), .MDRout(mdr6), .busy(busy6),
        .done(done6), .err(err6)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model of the 32-bit instance
    logic [31:0] m_mdr;
    bit          m_busy, m_done, m_err;
    int          m_waited;
    logic [1:0]  m_sz;
    bit          m_se;
    int          m_a;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_extract(input logic [31:0] d, input logic [1:0] sz,
                                              input bit se, input int a);
        int          nb;
        logic [31:0] mask, v;
        nb   = nbytes(sz);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v    = (d >> (8 * a)) & mask;
        if (se && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_reset();
        m_mdr = RV; m_busy = 0; m_done = 0; m_err = 0; m_waited = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!m_busy) begin
            if (enable && !read) begin
                m_mdr = bus;
            end else if (enable && read) begin
                m_sz = size; m_se = sign_ext; m_a = int'(addr);
                m_err = (m_a % nbytes(size)) != 0;
                if (!m_err) begin
                    m_busy = 1; m_waited = 0;
                end
            end
        end else if (mem_ack) begin
            m_mdr = m_extract(mdat, m_sz, m_se, m_a);
            m_busy = 0; m_done = 1;
        end else begin
            m_waited++;
            if (m_waited == TO) begin
                m_err = 1; m_busy = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("MDRout", 64'(mdr), 64'(m_mdr));
        chk("mem_req", 64'(mem_req), 64'(m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic do_read(input logic [1:0] sz, input bit se, input logic [1:0] a,
                           input logic [31:0] data, input int waits);
        enable = 1; read = 1; size = sz; sign_ext = se; addr = a;
        step();
        enable = 0; read = 0; mem_ack = 0;
        repeat (waits) step();
        mem_ack = 1; mdat = data;
        step();
        mem_ack = 0;
    endtask

    task automatic step6(input int n);
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pct;
        clr = 0; enable = 0; read = 0; sign_ext = 0; mem_ack = 0;
        bus = '0; mdat = '0; size = '0; addr = '0;
        enable6 = 0; read6 = 0; sext6 = 0; ack6 = 0; bus6 = '0; mdat6 = '0;
        size6 = '0; addr6 = '0;
        #12;
        chk("reset_mdr", 64'(mdr), 64'h0000_A5A5);
        chk("reset_flags", 64'({mem_req, busy, done, err}), 64'h0);
        model_reset();
        @(negedge clk) clr = 1;

        // Direct load
        enable = 1; read = 0; bus = 32'hDEADBEEF;
        step();
        chk("direct_load", 64'(mdr), 64'hDEAD_BEEF);
        enable = 0;
        step();
        chk("direct_noreq", 64'(mem_req), 64'h0);

        // Byte reads, sign and zero extended
        do_read(2'b00, 1, 2'd2, 32'h0080_0000, 3);
        chk("byte_sext", 64'(mdr), 64'hFFFF_FF80);
        chk("byte_done", 64'(done), 64'h1);
        step();
        chk("byte_done_drop", 64'(done), 64'h0);
        do_read(2'b00, 0, 2'd2, 32'h0080_0000, 0);
        chk("byte_zext", 64'(mdr), 64'h0000_0080);

        // Half read, then misaligned half
        do_read(2'b01, 0, 2'd2, 32'h8001_1234, 1);
        chk("half_zext", 64'(mdr), 64'h0000_8001);
        enable = 1; read = 1; size = 2'b01; addr = 2'd1;
        step();
        enable = 0; read = 0;
        chk("misalign_err", 64'(err), 64'h1);
        chk("misalign_noreq", 64'(mem_req), 64'h0);
        step6(3);

        // Timeout on an aligned word read
        enable = 1; read = 1; size = 2'b10; addr = 2'd0; mem_ack = 0;
        step();
        enable = 0; read = 0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        chk("timeout_len", 64'(n), 64'd15);
        chk("timeout_err", 64'(err), 64'h1);
        chk("timeout_keep", 64'(mdr), 64'h0000_8001);
        do_read(2'b10, 0, 2'd0, 32'h1357_9BDF, 2);
        chk("err_cleared", 64'(err), 64'h0);
        chk("word_read", 64'(mdr), 64'h1357_9BDF);

        // Asynchronous reset in the middle of a read
        enable = 1; read = 1; size = 2'b00; addr = 2'd3;
        step();
        enable = 0; read = 0;
        #2 clr = 0;
        #2;
        chk("async_rst_mdr", 64'(mdr), 64'h0000_A5A5);
        chk("async_rst_flags", 64'({mem_req, busy, done, err}), 64'h0);
        model_reset();
        #1 clr = 1;

        // 64-bit instance
        enable6 = 1; read6 = 1; size6 = 2'b10; addr6 = 3'd0;
        step();
        enable6 = 0; read6 = 0;
        chk("w64_busy", 64'(busy6), 64'h1);
        ack6 = 1; mdat6 = 64'h0123_4567_89AB_CDEF;
        step();
        ack6 = 0;
        chk("w64_word", mdr6, 64'h0123_4567_89AB_CDEF);
        chk("w64_done", 64'(done6), 64'h1);
        enable6 = 1; read6 = 1; size6 = 2'b00; sext6 = 0; addr6 = 3'd7;
        step();
        read6 = 0; bus6 = '1;
        step();
        read6 = 1; size6 = 2'b10; addr6 = 3'd0;
        step();
        enable6 = 0; read6 = 0;
        chk("w64_ignore_en", mdr6, 64'h0123_4567_89AB_CDEF);
        chk("w64_still_busy", 64'(busy6), 64'h1);
        ack6 = 1; mdat6 = 64'h0123_4567_89AB_CDEF;
        step();
        ack6 = 0;
        chk("w64_byte7", mdr6, 64'h0000_0000_0000_0001);
        enable6 = 1; read6 = 1; size6 = 2'b10; addr6 = 3'd0;
        step();
        enable6 = 0; read6 = 0;
        n = 0;
        while (req6 && n < 20) begin
            n++;
            step();
        end
        chk("w64_timeout_len", 64'(n), 64'd4);
        chk("w64_timeout_err", 64'(err6), 64'h1);

        // Randomized traffic against the model
        pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 5;
                    2: pct = 30;
                    default: pct = 90;
                endcase
            end
            enable   = ($urandom_range(0, 2) == 0);
            read     = $urandom_range(0, 1) == 1;
            size     = 2'($urandom_range(0, 3));
            sign_ext = $urandom_range(0, 1) == 1;
            addr     = 2'($urandom_range(0, 3));
            bus      = $urandom;
            mdat     = $urandom;
            mem_ack  = ($urandom_range(0, 99) < pct);
            if (i % 700 == 350) begin
                @(negedge clk);
                clr = 0;
                #1;
                chk("rand_rst_mdr", 64'(mdr), 64'(RV));
                chk("rand_rst_flags", 64'({mem_req, busy, done, err}), 64'h0);
                model_reset();
                #1 clr = 1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
